vga_scan_gen: RTL

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz board clock. Drives the scan coordinates `cx`/`cy` consumed by every drawing primitive (tiles, squares, text), and applies blanking. Registers the composed 12-bit pixel colour onto the VGA pins with sync aligned to it. Sits at the top of the video path, between the board clock and the drawing logic.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_scan_gen_if.sv | 37 +++
 rtl/vga_axis_counter.sv | 50 +++++
 rtl/vga_scan_gen.sv | 137 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, sync polarity and the 12-bit colour type.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Level driven on Hsync/Vsync while inside the sync pulse.
  localparam logic SYNC_POL = 1'b0;

  localparam int unsigned R_W = 4;
  localparam int unsigned G_W = 4;
  localparam int unsigned B_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb_t;

  function automatic logic sync_level(input logic in_sync);
    return in_sync ? SYNC_POL : ~SYNC_POL;
  endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Video bundle between the scan generator, the drawing logic and the pins.
// Carries frame_cnt only when VGA_FRAME_CNT_EN is defined.
interface vga_scan_gen_if;
  import vga_pkg::*;

  rgb_t       color;
  cnt_t       cx;
  cnt_t       cy;
  logic       active;
  logic       pix_tick;
  logic       frame_start;
  logic       Hsync;
  logic       Vsync;
  logic [R_W-1:0] VGA_R;
  logic [G_W-1:0] VGA_G;
  logic [B_W-1:0] VGA_B;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    input  color,
    output cx, cy, active, pix_tick, frame_start, Hsync, Vsync, VGA_R, VGA_G, VGA_B
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output color,
    input  cx, cy, active, pix_tick, frame_start, Hsync, Vsync, VGA_R, VGA_G, VGA_B
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter resetting to its last count, with terminal-count,
// sync-range and next-count active decodes.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output cnt_t count_o,
  output logic tc_o,
  output logic in_sync_o,
  output logic active_next_o
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam cnt_t        LAST       = cnt_t'(TOTAL - 1);
  localparam cnt_t        SYNC_FIRST = cnt_t'(ACTIVE + FP);
  localparam cnt_t        SYNC_LAST  = cnt_t'(ACTIVE + FP + SYNC - 1);
  localparam cnt_t        ACT_END    = cnt_t'(ACTIVE);

  cnt_t count_q, count_d;
  logic tc;

  assign tc = (count_q == LAST);

  // NOTE: count_d gets its hold value first, so every path assigns it and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values simultaneously.
  always_ff @(posedge clk) begin
    if (rst) count_q <= LAST;
    else     count_q <= count_d;
  end

  assign count_o       = count_q;
  assign tc_o          = tc;
  assign in_sync_o     = (count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST);
  assign active_next_o = (count_d < ACT_END);

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator with a registered, blank-gated colour/sync pin stage.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame counter output.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input logic             clk,
  input logic             rst,
  vga_scan_gen_if.master  vga
);

  localparam int unsigned         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick_q, pix_tick_d;

  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_tick_d = (div_q == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  cnt_t cx, cy;
  logic h_tc, v_tc, h_in_sync, v_in_sync, h_act_next, v_act_next;
  logic v_en;

  assign v_en = pix_tick_q & h_tc;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
  ) u_h_cnt (
    .clk           (clk),
    .rst           (rst),
    .en_i          (pix_tick_q),
    .count_o       (cx),
    .tc_o          (h_tc),
    .in_sync_o     (h_in_sync),
    .active_next_o (h_act_next)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
  ) u_v_cnt (
    .clk           (clk),
    .rst           (rst),
    .en_i          (v_en),
    .count_o       (cy),
    .tc_o          (v_tc),
    .in_sync_o     (v_in_sync),
    .active_next_o (v_act_next)
  );

  logic active_q, active_d;
  logic frame_start_q, frame_start_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  rgb_t rgb_q, rgb_d;

  // Pin stage samples the pre-edge count/active, so it trails cx/cy by one pixel.
  always_comb begin
    active_d      = active_q;
    frame_start_d = 1'b0;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    if (pix_tick_q) begin
      active_d      = h_act_next & v_act_next;
      frame_start_d = v_en & v_tc;
      hsync_d       = sync_level(h_in_sync);
      vsync_d       = sync_level(v_in_sync);
      rgb_d         = active_q ? vga.color : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      rgb_q         <= '0;
    end else begin
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.cx          = cx;
  assign vga.cy          = cy;
  assign vga.active      = active_q;
  assign vga.pix_tick    = pix_tick_q;
  assign vga.frame_start = frame_start_q;
  assign vga.Hsync       = hsync_q;
  assign vga.Vsync       = vsync_q;
  assign vga.VGA_R       = rgb_q.r;
  assign vga.VGA_G       = rgb_q.g;
  assign vga.VGA_B       = rgb_q.b;

endmodule
